// File: rtl/arb_stream_pkg.sv
// rtl/arb_stream_pkg.sv - shared arbiter stream field layout, K code and FSM encodings
package arb_stream_pkg;

  localparam int HDR_FLAG_BIT = 15;
  localparam int CH_MSB       = 14;
  localparam int CH_LSB       = 11;
  localparam int LEN_MSB      = 10;
  localparam int LEN_LSB      = 0;

  localparam logic [15:0] K_CODE = 16'h00BC;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PAYLOAD = 1'b1;

  typedef struct packed {
    logic        is_hdr;
    logic [3:0]  ch;
    logic [10:0] len;
  } hdr_t;

  // Split a raw stream word into header fields; is_hdr is only the flag bit.
  function automatic hdr_t hdr_decode(input logic [15:0] word);
    hdr_t h;
    h.is_hdr = word[HDR_FLAG_BIT];
    h.ch     = word[CH_MSB:CH_LSB];
    h.len    = word[LEN_MSB:LEN_LSB];
    return h;
  endfunction

endpackage

// File: rtl/sat_cnt16.sv
// rtl/sat_cnt16.sv - 16-bit up counter with enable that sticks at all-ones
module sat_cnt16 (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic [15:0] o_cnt
);

  logic [15:0] r_cnt;

  // Count on enable, hold once the top value is reached.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/arb_stream_rx.sv
// rtl/arb_stream_rx.sv - arbiter stream receiver: header decode, payload framing, counters
module arb_stream_rx
  import arb_stream_pkg::*;
#(
  parameter int MAXLEN = 1024,
  parameter int CHANS  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din,
  input  logic        kchar,
  output logic [15:0] dout,
  output logic [3:0]  ch,
  output logic        dvalid,
  output logic        sop,
  output logic        eop,
  output logic        err,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [11:0] LP_MAXLEN = 12'(MAXLEN);
  localparam logic [4:0]  LP_CHANS  = 5'(CHANS);

  logic        r_run;
  logic [0:0]  r_state;
  logic [10:0] r_rem;
  logic [10:0] r_len;
  logic [3:0]  r_ch;
  logic [15:0] r_dout;
  logic        r_dvalid;
  logic        r_sop;
  logic        r_eop;
  logic        r_err;

  hdr_t        w_hdr;
  logic        w_hdr_legal;
  logic        w_idle_dec;
  logic        w_pay_dec;
  logic        w_take;
  logic        w_abort;
  logic        w_last;
  logic        w_open;
  logic        w_empty;
  logic        w_err;
  logic        w_pkt;

  assign w_hdr       = hdr_decode(din);
  assign w_hdr_legal = w_hdr.is_hdr
                     && ({1'b0, w_hdr.len} <= LP_MAXLEN)
                     && ({1'b0, w_hdr.ch} < LP_CHANS);

  // K symbols in IDLE are simply skipped, so only data words reach the decoder.
  assign w_idle_dec = r_run && (r_state == ST_IDLE) && !kchar;
  assign w_pay_dec  = r_run && (r_state == ST_PAYLOAD);
  assign w_take     = w_pay_dec && !kchar;
  assign w_abort    = w_pay_dec && kchar;
  assign w_last     = w_take && (r_rem == 11'd1);
  assign w_open     = w_idle_dec && w_hdr_legal && (w_hdr.len != 11'd0);
  assign w_empty    = w_idle_dec && w_hdr_legal && (w_hdr.len == 11'd0);
  assign w_err      = (w_idle_dec && !w_hdr_legal) || w_abort;
  assign w_pkt      = w_empty || w_last;

  // Reset release flop: decoding starts one edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Framing FSM, remaining-word counter and registered output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rem    <= '0;
      r_len    <= '0;
      r_ch     <= '0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_dvalid <= w_take;
      r_sop    <= w_take && (r_rem == r_len);
      r_eop    <= w_last;
      r_err    <= w_err;
      if (w_take) begin
        r_dout <= din;
      end
      if (w_open) begin
        r_state <= ST_PAYLOAD;
        r_ch    <= w_hdr.ch;
        r_len   <= w_hdr.len;
        r_rem   <= w_hdr.len;
      end else if (w_take) begin
        r_rem <= r_rem - 11'd1;
        if (w_last) begin
          r_state <= ST_IDLE;
        end
      end else if (w_abort) begin
        r_state <= ST_IDLE;
        r_rem   <= '0;
      end
    end
  end

  sat_cnt16 u_pkt_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (w_pkt),
    .o_cnt   (pkt_cnt)
  );

  sat_cnt16 u_err_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (w_err),
    .o_cnt   (err_cnt)
  );

  assign dout   = r_dout;
  assign ch     = r_ch;
  assign dvalid = r_dvalid;
  assign sop    = r_sop;
  assign eop    = r_eop;
  assign err    = r_err;

endmodule

// File: tb/tb_arb_stream_rx.sv
// tb/tb_arb_stream_rx.sv - directed bench for arb_stream_rx with packet-level reference model
module tb_arb_stream_rx;

  localparam int MAXLEN = 1024;
  localparam int CHANS  = 16;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        kchar;
  logic [15:0] dout;
  logic [3:0]  ch;
  logic        dvalid;
  logic        sop;
  logic        eop;
  logic        err;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: packet-level view of the stream.
  bit          rst_req = 1'b0;
  bit          m_armed = 1'b0;
  bit          m_in    = 1'b0;
  int          m_left  = 0;
  int          m_total = 0;
  int          m_pk    = 0;
  int          m_er    = 0;
  logic [3:0]  m_ch    = '0;

  // Expected outputs after the coming edge.
  bit          e_rst  = 1'b1;
  logic        e_dv   = 1'b0;
  logic        e_sop  = 1'b0;
  logic        e_eop  = 1'b0;
  logic        e_err  = 1'b0;
  logic [15:0] e_dout = '0;
  logic [3:0]  e_ch   = '0;
  logic [15:0] e_pkt  = '0;
  logic [15:0] e_ecnt = '0;

  arb_stream_rx #(.MAXLEN(MAXLEN), .CHANS(CHANS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .kchar   (kchar),
    .dout    (dout),
    .ch      (ch),
    .dvalid  (dvalid),
    .sop     (sop),
    .eop     (eop),
    .err     (err),
    .pkt_cnt (pkt_cnt),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  // Predict the effect of the word on din/kchar at the next rising edge.
  task automatic model_step();
    logic [15:0] w;
    int          len;
    int          chn;
    w = din;
    e_dv = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_err = 1'b0;
    if (!rst_n) begin
      e_rst = 1'b1;
      m_armed = 1'b0; m_in = 1'b0; m_left = 0; m_pk = 0; m_er = 0; m_ch = '0;
      e_dout = '0; e_ch = '0;
    end else begin
      e_rst = 1'b0;
      if (!m_armed) begin
        m_armed = 1'b1;
      end else if (!m_in) begin
        if (!kchar) begin
          len = int'(w[10:0]);
          chn = int'(w[14:11]);
          if (!w[15] || len > MAXLEN || chn >= CHANS) begin
            e_err = 1'b1; m_er++;
          end else if (len == 0) begin
            m_pk++;
          end else begin
            m_in = 1'b1; m_left = len; m_total = len; m_ch = w[14:11];
          end
        end
      end else if (kchar) begin
        e_err = 1'b1; m_er++; m_in = 1'b0;
      end else begin
        e_dv = 1'b1; e_dout = w; e_ch = m_ch;
        e_sop = (m_left == m_total);
        m_left--;
        e_eop = (m_left == 0);
        if (m_left == 0) begin
          m_pk++; m_in = 1'b0;
        end
      end
    end
    e_pkt  = sat16(m_pk);
    e_ecnt = sat16(m_er);
  endtask

  task automatic cycle(input logic [15:0] w, input logic k);
    @(negedge clk);
    rst_n = rst_req;
    din   = w;
    kchar = k;
    model_step();
    @(posedge clk);
    #2;
  endtask

  // Compare every cycle against the model, just after the edge.
  always @(posedge clk) begin
    #1;
    check("dvalid", {15'd0, dvalid}, {15'd0, e_dv});
    check("err", {15'd0, err}, {15'd0, e_err});
    check("pkt_cnt", pkt_cnt, e_pkt);
    check("err_cnt", err_cnt, e_ecnt);
    if (e_rst || e_dv) begin
      check("dout", dout, e_dout);
      check("ch", {12'd0, ch}, {12'd0, e_ch});
      check("sop", {15'd0, sop}, {15'd0, e_sop});
      check("eop", {15'd0, eop}, {15'd0, e_eop});
    end
  end

  initial begin
    rst_n = 1'b0;
    din   = 16'h0000;
    kchar = 1'b0;

    // Reset state.
    repeat (3) cycle(16'h1234, 1'b0);
    check("rst_pkt_cnt", pkt_cnt, 16'h0000);
    check("rst_dvalid", {15'd0, dvalid}, 16'h0000);

    // Release, then idle K stream.
    rst_req = 1'b1;
    repeat (3) cycle(16'h00BC, 1'b1);

    // Basic three-word packet on channel 2.
    cycle(16'h9003, 1'b0);
    cycle(16'h0010, 1'b0);
    check("p1_sop", {15'd0, sop}, 16'h0001);
    check("p1_ch", {12'd0, ch}, 16'h0002);
    cycle(16'h0011, 1'b0);
    cycle(16'h0012, 1'b0);
    check("p1_eop", {15'd0, eop}, 16'h0001);
    check("p1_pkt_cnt", pkt_cnt, 16'h0001);
    cycle(16'h00BC, 1'b1);

    // Length-one packet: sop and eop together.
    cycle(16'h8801, 1'b0);
    cycle(16'h1234, 1'b0);
    check("p2_sop_eop", {14'd0, sop, eop}, 16'h0003);
    check("p2_dout", dout, 16'h1234);
    check("p2_pkt_cnt", pkt_cnt, 16'h0002);

    // Abort on K symbol mid-packet.
    cycle(16'hA804, 1'b0);
    cycle(16'h0A0A, 1'b0);
    cycle(16'h0B0B, 1'b0);
    cycle(16'h00BC, 1'b1);
    check("abort_err", {15'd0, err}, 16'h0001);
    check("abort_err_cnt", err_cnt, 16'h0001);
    check("abort_pkt_cnt", pkt_cnt, 16'h0002);
    cycle(16'h00BC, 1'b1);

    // Over-length header and stray data word in IDLE.
    cycle(16'h844C, 1'b0);
    check("len1100_err", {15'd0, err}, 16'h0001);
    cycle(16'h00BC, 1'b1);
    cycle(16'h0042, 1'b0);
    check("stray_err_cnt", err_cnt, 16'h0003);
    cycle(16'h8401, 1'b0);
    check("len1025_err_cnt", err_cnt, 16'h0004);

    // Exactly MAXLEN words is legal.
    cycle(16'h8400, 1'b0);
    for (int i = 0; i < MAXLEN; i++) cycle(16'(i * 3), 1'b0);
    check("maxlen_pkt_cnt", pkt_cnt, 16'h0003);

    // Zero-length header, then back-to-back packets with no gap.
    cycle(16'hF800, 1'b0);
    check("len0_pkt_cnt", pkt_cnt, 16'h0004);
    cycle(16'h8002, 1'b0);
    cycle(16'hC0DE, 1'b0);
    cycle(16'hBEEF, 1'b0);
    check("b2b_pkt_cnt", pkt_cnt, 16'h0005);
    cycle(16'h8801, 1'b0);
    cycle(16'h5555, 1'b0);
    check("b2b2_sop_eop", {14'd0, sop, eop}, 16'h0003);

    // Reset pulsed during word 2 of a length-5 packet.
    cycle(16'h9805, 1'b0);
    cycle(16'h0001, 1'b0);
    @(negedge clk);
    din = 16'h0002; kchar = 1'b0;
    #2;
    rst_req = 1'b0;
    rst_n   = 1'b0;
    model_step();
    #1;
    check("mid_rst_pkt_cnt", pkt_cnt, 16'h0000);
    check("mid_rst_dout", dout, 16'h0000);
    @(posedge clk);
    #2;
    cycle(16'h0003, 1'b0);
    cycle(16'h0004, 1'b0);
    rst_req = 1'b1;
    cycle(16'h00BC, 1'b1);
    cycle(16'h00BC, 1'b1);
    cycle(16'h8801, 1'b0);
    cycle(16'h7777, 1'b0);
    check("post_rst_dout", dout, 16'h7777);
    check("post_rst_pkt_cnt", pkt_cnt, 16'h0001);
    check("post_rst_err_cnt", err_cnt, 16'h0000);
    cycle(16'h00BC, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
